ntt_ctrl: RTL and testbench

Sequencer that runs one full 256-point Kyber forward or inverse NTT in place over the coefficient memory, one butterfly per cycle. It issues paired read addresses and a twiddle-ROM index to the memory, ROM and butterfly unit. It drives the butterfly mode. It replays the addresses as delayed write-backs, aligned to memory and butterfly latency. It sits directly upstream of the butterfly unit and owns all layer and address sequencing.

---
 rtl/ntt_pkg.sv | 30 +++
 rtl/ntt_addr_gen.sv | 44 ++++
 rtl/ntt_ctrl.sv | 172 +++++++++++++++++
 tb/tb_ntt_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// ntt_pkg : shared NTT sizes, butterfly mode codes and sequencer states. rev 1.0
// ------------------------------------------------------------------------
package ntt_pkg;

  localparam int N      = 256;
  localparam int LOG_N  = 8;
  localparam int LAYERS = 7;

  localparam logic [1:0] BU_MODE_NTT    = 2'd0;
  localparam logic [1:0] BU_MODE_INTT   = 2'd1;
  localparam logic [1:0] BU_MODE_MUL1   = 2'd2;
  localparam logic [1:0] BU_MODE_ADDSUB = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } ntt_state_e;

  typedef struct packed {
    logic             valid;
    logic [LOG_N-1:0] addr_u;
    logic [LOG_N-1:0] addr_t;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/ntt_addr_gen.sv
`default_nettype none
// ------------------------------------------------------------------------
// ntt_addr_gen : butterfly pair addresses and twiddle index from (layer, b, inv).
// Inverse sequencing compiled only with NTT_CTRL_INTT_EN.                rev 1.0
// ------------------------------------------------------------------------
module ntt_addr_gen
  import ntt_pkg::*;
(
  input  logic [2:0]       layer,
  input  logic [6:0]       bfly,
  input  logic             inv,
  output logic [LOG_N-1:0] addr_u,
  output logic [LOG_N-1:0] addr_t,
  output logic [6:0]       zeta
);

  logic [7:0] len;
  logic [6:0] mask;
  logic [6:0] grp;

  always_comb begin
    len  = 8'd128 >> layer;
    grp  = bfly >> (3'd7 - layer);
    zeta = (7'd1 << layer) + grp;
`ifdef NTT_CTRL_INTT_EN
    if (inv) begin
      len  = 8'd2 << layer;
      grp  = bfly >> (layer + 3'd1);
      zeta = (7'd127 >> layer) - grp;
    end
`endif
    // len is a power of two, so g*2*len + (b mod len) is a bit-level split of b
    mask   = len[6:0] - 7'd1;
    addr_u = {bfly & ~mask, 1'b0} | {1'b0, bfly & mask};
    addr_t = addr_u | len;
  end

`ifndef NTT_CTRL_INTT_EN
  logic unused_inv;
  assign unused_inv = inv;
`endif

endmodule
`default_nettype wire

// File: rtl/ntt_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------------
// ntt_ctrl : in-place 256-point Kyber NTT/INTT sequencer with delayed write-back.
// NTT_CTRL_INTT_EN enables inverse operation via inv.                    rev 1.0
// ------------------------------------------------------------------------
module ntt_ctrl
  import ntt_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int BU_LAT  = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       inv,
  output logic       busy,
  output logic       done,
  output logic [1:0] bu_mode,
  output logic       rd_en,
  output logic [7:0] rd_addr_u,
  output logic [7:0] rd_addr_t,
  output logic [6:0] zeta_addr,
  output logic       wr_en,
  output logic [7:0] wr_addr_u,
  output logic [7:0] wr_addr_t
);

  localparam int         D          = MEM_LAT + BU_LAT;
  localparam logic [2:0] LAST_LAYER = 3'(LAYERS - 1);
  localparam logic [7:0] DRAIN_LAST = 8'(D - 1);

  ntt_state_e state_q, state_d;
  logic [2:0] layer_q, layer_d;
  logic [6:0] bfly_q, bfly_d;
  logic [7:0] drain_q, drain_d;
  logic       inv_q, inv_d;

  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       rd_en_q, rd_en_d;
  logic [1:0] bu_mode_q, bu_mode_d;
  logic [7:0] rd_addr_u_q, rd_addr_u_d;
  logic [7:0] rd_addr_t_q, rd_addr_t_d;
  logic [6:0] zeta_addr_q, zeta_addr_d;

  logic [7:0] gen_u, gen_t;
  logic [6:0] gen_z;

  wb_entry_t wb_q [0:D-1];
  wb_entry_t wb_d [0:D-1];

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    bfly_d  = bfly_q;
    drain_d = drain_q;
    inv_d   = inv_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ISSUE;
          layer_d = 3'd0;
          bfly_d  = 7'd0;
`ifdef NTT_CTRL_INTT_EN
          inv_d   = inv;
`else
          inv_d   = 1'b0;
`endif
        end
      end
      ST_ISSUE: begin
        if (bfly_q == 7'd127) begin
          state_d = ST_DRAIN;
          drain_d = 8'd0;
        end else begin
          bfly_d = bfly_q + 7'd1;
        end
      end
      ST_DRAIN: begin
        // the last write of this layer lands in the final drain cycle
        if (drain_q == DRAIN_LAST) begin
          if (layer_q == LAST_LAYER) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ISSUE;
            layer_d = layer_q + 3'd1;
            bfly_d  = 7'd0;
          end
        end else begin
          drain_d = drain_q + 8'd1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  ntt_addr_gen u_addr_gen (
    .layer  (layer_d),
    .bfly   (bfly_d),
    .inv    (inv_d),
    .addr_u (gen_u),
    .addr_t (gen_t),
    .zeta   (gen_z)
  );

  // outputs are registered from the next-state view so they align with the state
  always_comb begin
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    rd_en_d     = (state_d == ST_ISSUE);
    bu_mode_d   = BU_MODE_NTT;
`ifdef NTT_CTRL_INTT_EN
    if (busy_d && inv_d) bu_mode_d = BU_MODE_INTT;
`endif
    rd_addr_u_d = rd_en_d ? gen_u : rd_addr_u_q;
    rd_addr_t_d = rd_en_d ? gen_t : rd_addr_t_q;
    zeta_addr_d = rd_en_d ? gen_z : zeta_addr_q;
    wb_d[0]     = {rd_en_q, rd_addr_u_q, rd_addr_t_q};
    for (int i = 1; i < D; i++) wb_d[i] = wb_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      layer_q     <= 3'd0;
      bfly_q      <= 7'd0;
      drain_q     <= 8'd0;
      inv_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      bu_mode_q   <= BU_MODE_NTT;
      rd_addr_u_q <= 8'd0;
      rd_addr_t_q <= 8'd0;
      zeta_addr_q <= 7'd0;
      for (int i = 0; i < D; i++) wb_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      layer_q     <= layer_d;
      bfly_q      <= bfly_d;
      drain_q     <= drain_d;
      inv_q       <= inv_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_en_q     <= rd_en_d;
      bu_mode_q   <= bu_mode_d;
      rd_addr_u_q <= rd_addr_u_d;
      rd_addr_t_q <= rd_addr_t_d;
      zeta_addr_q <= zeta_addr_d;
      for (int i = 0; i < D; i++) wb_q[i] <= wb_d[i];
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign bu_mode   = bu_mode_q;
  assign rd_en     = rd_en_q;
  assign rd_addr_u = rd_addr_u_q;
  assign rd_addr_t = rd_addr_t_q;
  assign zeta_addr = zeta_addr_q;
  assign wr_en     = wb_q[D-1].valid;
  assign wr_addr_u = wb_q[D-1].addr_u;
  assign wr_addr_t = wb_q[D-1].addr_t;

`ifndef NTT_CTRL_INTT_EN
  logic unused_inv;
  assign unused_inv = inv;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ntt_ctrl.sv
`default_nettype none
// tb_ntt_ctrl : cycle schedule model plus memory/butterfly model against a golden Kyber NTT.
module tb_ntt_ctrl;
  import ntt_pkg::*;

  localparam int MEM_LAT = 1;
  localparam int BU_LAT  = 5;
  localparam int D       = MEM_LAT + BU_LAT;
  localparam int PERIOD  = 128 + D;
  localparam int DONE_N  = 1 + 7 * PERIOD;
  localparam int Q       = 3329;
`ifdef NTT_CTRL_INTT_EN
  localparam bit INV_OK = 1'b1;
`else
  localparam bit INV_OK = 1'b0;
`endif

  logic       clk, rst, start, inv;
  logic       busy, done, rd_en, wr_en;
  logic [1:0] bu_mode;
  logic [7:0] rd_addr_u, rd_addr_t, wr_addr_u, wr_addr_t;
  logic [6:0] zeta_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ntt_ctrl #(.MEM_LAT(MEM_LAT), .BU_LAT(BU_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .inv(inv),
    .busy(busy), .done(done), .bu_mode(bu_mode),
    .rd_en(rd_en), .rd_addr_u(rd_addr_u), .rd_addr_t(rd_addr_t), .zeta_addr(zeta_addr),
    .wr_en(wr_en), .wr_addr_u(wr_addr_u), .wr_addr_t(wr_addr_t)
  );

  typedef struct { bit inv; int l; int b; int u; int t; int z; int mode; } vec_t;
  vec_t        tbl [8];
  int          checks = 0;
  int          errors = 0;
  int          zetas [128];
  int          mem [256];
  int          gold [256];
  int          pend [$];
  logic [24:0] obs [2][7][128];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Read schedule: cycle n after the start edge -> (layer, b) if a read is due
  function automatic bit sched_rd(input int n, output int l, output int b);
    l = 0; b = 0;
    if (n < 1 || n >= DONE_N) return 1'b0;
    l = (n - 1) / PERIOD;
    b = (n - 1) % PERIOD;
    return b < 128;
  endfunction

  function automatic void ref_addr(input int l, input int b, input bit iv,
                                   output int u, output int t, output int z);
    int len, g;
    len = iv ? (2 << l) : (128 >> l);
    g   = b / len;
    u   = g * 2 * len + b % len;
    t   = u + len;
    z   = iv ? (128 >> l) - 1 - g : (1 << l) + g;
  endfunction

  function automatic void bu(input bit iv, input int zz, input int a, input int c,
                             output int nu, output int nt);
    int m;
    if (!iv) begin
      m  = (zz * c) % Q;
      nu = (a + m) % Q;
      nt = (a - m + Q) % Q;
    end else begin
      nu = (a + c) % Q;
      nt = (zz * ((c - a + Q) % Q)) % Q;
    end
  endfunction

  function automatic void golden(input bit iv);
    int k, len, zz, nu, nt;
    k   = iv ? 127 : 1;
    len = iv ? 2 : 128;
    for (int layer = 0; layer < 7; layer++) begin
      for (int s = 0; s < 256; s += 2 * len) begin
        zz = zetas[k];
        k  = iv ? k - 1 : k + 1;
        for (int j = s; j < s + len; j++) begin
          bu(iv, zz, gold[j], gold[j+len], nu, nt);
          gold[j] = nu;
          gold[j+len] = nt;
        end
      end
      len = iv ? len * 2 : len / 2;
    end
  endfunction

  task automatic run_op(input bit inv_val, input bit disturb, input int rst_at,
                        input bit btb, input int rec);
    bit         eff, er, ew;
    int         rdc, wrc, mis, l, b, lw, bw, u, t, z, nu, nt;
    logic [1:0] em;
    eff = inv_val && INV_OK;
    for (int i = 0; i < 256; i++) begin
      mem[i]  = int'($urandom_range(Q - 1, 0));
      gold[i] = mem[i];
    end
    golden(eff);
    pend.delete();
    rdc = 0;
    wrc = 0;
    @(negedge clk);
    start = 1'b1;
    inv   = inv_val;
    for (int n = 1; n <= DONE_N + 1; n++) begin
      @(negedge clk);
      er = sched_rd(n, l, b);
      ew = sched_rd(n - D, lw, bw);
      em = ((n <= DONE_N) && eff) ? BU_MODE_INTT : BU_MODE_NTT;
      check($sformatf("ctrl@%0d", n), {busy, done, bu_mode, rd_en, wr_en},
            {(n <= DONE_N), (n == DONE_N), em, er, ew});
      if (er) begin
        ref_addr(l, b, eff, u, t, z);
        check($sformatf("rd_addr@%0d", n), {rd_addr_u, rd_addr_t, zeta_addr}, {u[7:0], t[7:0], z[6:0]});
        if (rec >= 0) obs[rec][l][b] = {bu_mode, rd_addr_u, rd_addr_t, zeta_addr};
      end
      if (ew) begin
        ref_addr(lw, bw, eff, u, t, z);
        check($sformatf("wr_addr@%0d", n), {wr_addr_u, wr_addr_t}, {u[7:0], t[7:0]});
      end
      // behavioural memory + butterfly: compute at read, commit at write-back
      if (wr_en) begin
        wrc++;
        if (pend.size() >= 2) begin
          mem[wr_addr_u] = pend.pop_front();
          mem[wr_addr_t] = pend.pop_front();
        end
      end
      if (rd_en) begin
        rdc++;
        bu(eff, zetas[zeta_addr], mem[rd_addr_u], mem[rd_addr_t], nu, nt);
        pend.push_back(nu);
        pend.push_back(nt);
      end
      if (n == rst_at) begin
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("reset_mid", {busy, done, bu_mode, rd_en, rd_addr_u, rd_addr_t, zeta_addr,
                            wr_en, wr_addr_u, wr_addr_t}, 45'd0);
        pend.delete();
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          check("post_reset_quiet", {busy, done, rd_en, wr_en}, 4'd0);
        end
        return;
      end
      start = (disturb && n < DONE_N - 5) ? 1'($urandom_range(1, 0))
                                          : (btb && n >= DONE_N);
      if (disturb) inv = 1'($urandom_range(1, 0));
    end
    check("rd_count", rdc, 896);
    check("wr_count", wrc, 896);
    mis = 0;
    for (int i = 0; i < 256; i++) if (mem[i] != gold[i]) mis++;
    check("mem_vs_golden", mis, 0);
    if (btb) begin
      @(negedge clk);
      start = 1'b0;
      ref_addr(0, 0, eff, u, t, z);
      check("btb_first_issue", {busy, rd_en, bu_mode, rd_addr_u, rd_addr_t, zeta_addr},
            {1'b1, 1'b1, (eff ? BU_MODE_INTT : BU_MODE_NTT), u[7:0], t[7:0], z[6:0]});
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      check("btb_reset", {busy, rd_en, wr_en, done}, 4'd0);
    end
  endtask

  initial begin
    int p, r;
    for (int i = 0; i < 128; i++) begin
      r = 0;
      for (int k = 0; k < 7; k++) r |= ((i >> k) & 1) << (6 - k);
      p = 1;
      for (int k = 0; k < r; k++) p = (p * 17) % Q;
      zetas[i] = p;
    end
    for (int a = 0; a < 2; a++)
      for (int l = 0; l < 7; l++)
        for (int b = 0; b < 128; b++) obs[a][l][b] = '0;

    tbl[0] = '{1'b0, 0,   0,   0, 128,   1, 0};
    tbl[1] = '{1'b0, 0, 127, 127, 255,   1, 0};
    tbl[2] = '{1'b0, 6,   0,   0,   2,  64, 0};
    tbl[3] = '{1'b0, 6,   1,   1,   3,  64, 0};
    tbl[4] = '{1'b0, 6,   2,   4,   6,  65, 0};
    tbl[5] = '{1'b0, 6, 127, 253, 255, 127, 0};
`ifdef NTT_CTRL_INTT_EN
    tbl[6] = '{1'b1, 0,   0,   0,   2, 127, 1};
    tbl[7] = '{1'b1, 6,   0,   0, 128,   1, 1};
`else
    tbl[6] = '{1'b1, 0,   0,   0, 128,   1, 0};
    tbl[7] = '{1'b1, 6,   0,   0,   2,  64, 0};
`endif

    rst   = 1'b0;
    start = 1'b0;
    inv   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", {busy, done, bu_mode, rd_en, rd_addr_u, rd_addr_t, zeta_addr,
                          wr_en, wr_addr_u, wr_addr_t}, 45'd0);
    rst = 1'b1;

    run_op(1'b0, 1'b0, -1, 1'b0, 0);
    run_op(1'b1, 1'b0, -1, 1'b0, 1);
    for (int i = 0; i < 8; i++)
      check($sformatf("vec%0d", i), obs[tbl[i].inv][tbl[i].l][tbl[i].b],
            {2'(tbl[i].mode), 8'(tbl[i].u), 8'(tbl[i].t), 7'(tbl[i].z)});

    run_op(1'b0, 1'b1, -1, 1'b0, -1);
    run_op(1'b1, 1'b1, -1, 1'b0, -1);
    run_op(1'b0, 1'b0, 1 + 3 * PERIOD + 40, 1'b0, -1);
    run_op(1'b0, 1'b0, -1, 1'b0, -1);
    run_op(1'b1, 1'b0, -1, 1'b1, -1);
    run_op(1'($urandom_range(1, 0)), 1'b1, -1, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
